// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder reusing one half-adder cell twice per bit position
module half_adder (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d, sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             s1_q, s1_d, c1_q, c1_d, carry_q, carry_d, c_out_q, c_out_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             ha_x, ha_y, ha_s, ha_c, last;
    logic [WIDTH:0]   res_sh;

    assign last   = idx_q == IW'(WIDTH - 1);
    assign ha_x   = (state_q == PH1) ? a_sh_q[0] : s1_q;
    assign ha_y   = (state_q == PH1) ? b_sh_q[0] : carry_q;
    assign res_sh = {ha_s, res_q};

    half_adder u_ha (
        .x_i(ha_x),
        .y_i(ha_y),
        .s_o(ha_s),
        .c_o(ha_c)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state: each bit costs a PH1/PH2 pair, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? PH1 : IDLE;
            PH1:     state_d = PH2;
            PH2:     state_d = last ? DONE : PH1;
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs are registered from the upcoming state
    always_comb begin
        busy_d = (state_d == PH1) || (state_d == PH2);
        done_d = state_d == DONE;
    end

    // datapath next-state: operand capture, half-adder passes, result shifting
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        s1_d    = s1_q;
        c1_d    = c1_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        if (state_q == IDLE && start) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = 1'b0;
            idx_d   = '0;
        end
        if (state_q == PH1) begin
            s1_d = ha_s;
            c1_d = ha_c;
        end
        if (state_q == PH2) begin
            res_d   = res_sh[WIDTH:1];
            carry_d = c1_q | ha_c;
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            idx_d   = idx_q + IW'(1);
            sum_d   = last ? res_sh[WIDTH:1] : sum_q;
            c_out_d = last ? (c1_q | ha_c) : c_out_q;
        end
    end

    // datapath and output registers; reset discards any in-flight result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and swept checks of the bit-serial adder at WIDTH=8 and WIDTH=1
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, c_out;
    logic [7:0] sum;
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       busy1, done1, c_out1;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1);
    end

    // present operands and pulse start for one accepting edge; returns at the negedge after it
    task automatic launch(input logic [7:0] x, input logic [7:0] y);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // cycles from the accepting edge until done is seen, counting cycles busy was low
    task automatic wait_done(output int lat, output int busy_low);
        lat = 0;
        busy_low = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0)  begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (sum !== 8'h00)  begin fails++; $display("FAIL reset_sum: got %h want 00", sum); end
        tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b want 0", c_out); end
        tests++; if ({busy1, done1, sum1, c_out1} !== 4'b0) begin fails++; $display("FAIL reset_w1: got %b want 0000", {busy1, done1, sum1, c_out1}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_no_start: busy got %b want 0", busy); end
    endtask

    task automatic test_zero;
        int lat, bl;
        launch(8'h00, 8'h00);
        wait_done(lat, bl);
        tests++; if (lat !== 16)    begin fails++; $display("FAIL zero_latency: got %0d want 16", lat); end
        tests++; if (bl !== 0)      begin fails++; $display("FAIL zero_busy: low for %0d cycles want 0", bl); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy_done: got %b want 0", busy); end
        tests++; if (sum !== 8'h00) begin fails++; $display("FAIL zero_sum: got %h want 00", sum); end
        tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL zero_cout: got %b want 0", c_out); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_pulse: done got %b want 0", done); end
    endtask

    task automatic test_back_to_back;
        int lat, bl, m;
        a = 8'hA5;
        b = 8'h5A;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        wait_done(lat, bl);
        tests++; if (lat !== 16)    begin fails++; $display("FAIL b2b_latency1: got %0d want 16", lat); end
        tests++; if (sum !== 8'hFF) begin fails++; $display("FAIL b2b_sum1: got %h want ff", sum); end
        tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL b2b_cout1: got %b want 0", c_out); end
        @(negedge clk);
        m = 1;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap: busy/done got %b%b want 00", busy, done); end
        while (done !== 1'b1 && m < 40) begin
            @(negedge clk);
            m++;
        end
        start = 1'b0;
        tests++; if (m !== 18)      begin fails++; $display("FAIL b2b_spacing: got %0d want 18", m); end
        tests++; if (sum !== 8'h02) begin fails++; $display("FAIL b2b_sum2: got %h want 02", sum); end
        tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL b2b_cout2: got %b want 0", c_out); end
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_no_requeue: busy got %b want 0", busy); end
    endtask

    task automatic test_ripple;
        int lat, bl;
        launch(8'hFF, 8'h01);
        repeat (8) @(negedge clk);
        tests++; if (sum !== 8'h02 || c_out !== 1'b0) begin fails++; $display("FAIL ripple_hold: got %b_%h want 0_02", c_out, sum); end
        wait_done(lat, bl);
        tests++; if (lat + 8 !== 16) begin fails++; $display("FAIL ripple_latency: got %0d want 16", lat + 8); end
        tests++; if (sum !== 8'h00)  begin fails++; $display("FAIL ripple_sum: got %h want 00", sum); end
        tests++; if (c_out !== 1'b1) begin fails++; $display("FAIL ripple_cout: got %b want 1", c_out); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, bl, seen;
        launch(8'h80, 8'h80);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL midrst_cout: got %b want 0", c_out); end
        tests++; if (sum !== 8'h00 || done !== 1'b0) begin fails++; $display("FAIL midrst_sum_done: got %h/%b want 00/0", sum, done); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_discard: activity in %0d cycles want 0", seen); end
        launch(8'h03, 8'h04);
        wait_done(lat, bl);
        tests++; if (lat !== 16)     begin fails++; $display("FAIL midrst_latency: got %0d want 16", lat); end
        tests++; if (sum !== 8'h07 || c_out !== 1'b0) begin fails++; $display("FAIL midrst_result: got %b_%h want 0_07", c_out, sum); end
        @(negedge clk);
    endtask

    task automatic test_width1;
        logic [2:0] vec [3] = '{3'b111, 3'b101, 3'b000};
        for (int i = 0; i < 3; i++) begin
            int lat;
            logic [1:0] exp;
            a1 = vec[i][2];
            b1 = vec[i][1];
            exp = {1'b0, vec[i][2]} + {1'b0, vec[i][1]};
            start1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            lat = 0;
            while (done1 !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            tests++; if (lat !== 2) begin fails++; $display("FAIL w1_latency[%0d]: got %0d want 2", i, lat); end
            tests++; if ({c_out1, sum1} !== exp) begin fails++; $display("FAIL w1_result[%0d]: got %b want %b", i, {c_out1, sum1}, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_sweep;
        int lat, bl, bad_lat, bad_sum, bad_pulse;
        logic [7:0] x, y;
        logic [8:0] exp;
        bad_lat = 0;
        bad_sum = 0;
        bad_pulse = 0;
        for (int i = 0; i < 500; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            exp = {1'b0, x} + {1'b0, y};
            launch(x, y);
            wait_done(lat, bl);
            if (lat != 16 || bl != 0) bad_lat++;
            if ({c_out, sum} !== exp) begin
                bad_sum++;
                if (bad_sum <= 5) $display("FAIL sweep_result: %h+%h got %h want %h", x, y, {c_out, sum}, exp);
            end
            @(negedge clk);
            if (done !== 1'b0) bad_pulse++;
        end
        tests++; if (bad_sum !== 0)   begin fails++; $display("FAIL sweep_sum: %0d wrong of 500 want 0", bad_sum); end
        tests++; if (bad_lat !== 0)   begin fails++; $display("FAIL sweep_latency: %0d wrong of 500 want 0", bad_lat); end
        tests++; if (bad_pulse !== 0) begin fails++; $display("FAIL sweep_pulse: %0d long pulses want 0", bad_pulse); end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_back_to_back;
        test_ripple;
        test_reset_mid;
        test_width1;
        test_sweep;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
